cpu6502_bus_responder: RTL

- Memory-side responder for the cpu6502 bus. It answers CPU reads by driving ready and read data, and absorbs CPU writes into a posted write buffer.
- It translates both onto a req/ack backing-memory port with variable latency.
- CPU write cycles cannot stall, because the core ORs write into its internal ready. Writes are therefore buffered, and reads are held off until the buffer drains.

---
 rtl/cpu6502_bus_pkg.sv | 19 +
 rtl/wbuf_fifo.sv | 69 ++++++
 rtl/cpu6502_bus_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu6502_bus_pkg.sv
// rtl/cpu6502_bus_pkg.sv - shared types and constants for the cpu6502 bus responder
package cpu6502_bus_pkg;

  localparam int ADDR_W_DEFAULT = 16;
  localparam int DATA_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_DATA = 2'd3
  } bus_state_e;

  // A buffered write entry is {addr, data}
  function automatic int wentry_width(input int addr_w);
    return addr_w + DATA_W;
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// rtl/wbuf_fifo.sv - posted-write FIFO with same-cycle push/pop at any occupancy
module wbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rptr_q];

  // A pop frees the head slot in the same edge, so a push into a full FIFO is still accepted
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/cpu6502_bus_responder.sv
// rtl/cpu6502_bus_responder.sv - cpu6502 memory-side responder: posted writes, stalled reads, req/ack memory port
module cpu6502_bus_responder
  import cpu6502_bus_pkg::*;
#(
  parameter int WBUF_DEPTH = 4,
  parameter int ADDR_W     = ADDR_W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic                        cpu_write,
  input  logic [7:0]                  cpu_wdata,
  output logic [7:0]                  cpu_rdata,
  output logic                        cpu_ready,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [7:0]                  mem_wdata,
  input  logic [7:0]                  mem_rdata,
  input  logic                        mem_ack,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_count,
  output logic                        wbuf_overflow
);

  localparam int ENTRY_W = wentry_width(ADDR_W);
  localparam int CNT_W   = $clog2(WBUF_DEPTH) + 1;

  bus_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              wbuf_overflow_q, wbuf_overflow_d;

  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_full, fifo_empty;
  logic               mem_done, wbuf_pop, drain_more;

  // An ack only counts against a live request
  assign mem_done   = mem_req_q && mem_ack;
  assign wbuf_pop   = (state_q == ST_WR) && mem_done;
  assign drain_more = (wbuf_count > CNT_W'(1)) || cpu_write;

  wbuf_fifo #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .push      (cpu_write),
    .push_data ({cpu_addr, cpu_wdata}),
    .pop       (wbuf_pop),
    .head_data (fifo_head),
    .count     (wbuf_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Draining always wins over a pending read, so reads never pass older writes
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_WR;
        end else if (!cpu_write) begin
          state_d = ST_RD;
        end
      end
      ST_WR: begin
        if ((mem_done && !drain_more) || (!mem_req_q && fifo_empty)) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (mem_done) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    cpu_rdata_d     = cpu_rdata_q;
    wbuf_overflow_d = wbuf_overflow_q | (cpu_write && fifo_full && !wbuf_pop);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          mem_req_d                 = 1'b1;
          mem_we_d                  = 1'b1;
          {mem_addr_d, mem_wdata_d} = fifo_head;
        end else if (!cpu_write) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = cpu_addr;
        end
      end
      ST_WR: begin
        // After each accepted write the request drops for one cycle while the new head settles
        if (mem_done) begin
          mem_req_d = 1'b0;
        end else if (!mem_req_q && !fifo_empty) begin
          mem_req_d                 = 1'b1;
          mem_we_d                  = 1'b1;
          {mem_addr_d, mem_wdata_d} = fifo_head;
        end
      end
      ST_RD: begin
        if (mem_done) begin
          mem_req_d   = 1'b0;
          cpu_rdata_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      cpu_rdata_q     <= '0;
      wbuf_overflow_q <= 1'b0;
    end else begin
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      cpu_rdata_q     <= cpu_rdata_d;
      wbuf_overflow_q <= wbuf_overflow_d;
    end
  end

  assign cpu_ready     = (state_q == ST_DATA);
  assign cpu_rdata     = cpu_rdata_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign wbuf_overflow = wbuf_overflow_q;

endmodule
